lc3_mem_arbiter: RTL and testbench
==================================

Name: lc3_mem_arbiter

Overview:
- Shares one single-ported unified memory between the LC3 fetch stage and the MemAccess stage.
- Instruction side: pc/instrmem_rd. Data side: Data_addr/Data_rd/Data_din.
- Serialises accesses to the memory with a small FSM and returns data to the originating stage with a one-cycle ack.
- Drives a stall indication to the pipeline controller and runs a watchdog on slow or dead memory.

Parameters:
- ADDR_W, 16, address width of all ports.
- DATA_W, 16, data width of all ports.
- TIMEOUT, 15, max cycles in an access state waiting for mem_ready; 0 disables the watchdog.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- i_req  in  1  instruction fetch request; held until i_ack.
- i_addr  in  ADDR_W  fetch address (pc).
- i_data  out  DATA_W  fetched instruction (Instr_dout).
- i_ack  out  1  one-cycle pulse; i_data valid in this cycle.
- d_req  in  1  data access request; held until d_ack.
- d_rd  in  1  1=read, 0=write.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  write data (Data_din).
- d_rdata  out  DATA_W  read data (Data_dout).
- d_ack  out  1  one-cycle completion pulse.
- mem_req  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid when mem_ready=1.
- mem_ready  in  1  memory completes the current access this cycle.
- stall  out  1  a request is pending and not yet acked.
- timeout_err  out  1  sticky watchdog flag.

Behaviour:
- Reset (async, active-high) forces:
  - state=IDLE, watchdog counter=0.
  - mem_req, mem_we, i_ack, d_ack, timeout_err = 0.
  - mem_addr, mem_wdata, i_data, d_rdata = 0.
- States: IDLE, IFETCH, DACC.
- IDLE:
  - d_req=1 (and d_ack=0): latch d_addr/d_wdata/~d_rd into mem_addr/mem_wdata/mem_we; mem_req<=1; go DACC.
  - Else i_req=1 (and i_ack=0): latch i_addr; mem_we<=0; mem_req<=1; go IFETCH.
  - Fixed priority: data beats instruction when both are pending, because the data access belongs to the older instruction.
  - A request whose ack is high in the current cycle is ignored. This prevents a double grant while the requester drops req.
- IFETCH/DACC:
  - mem_req, mem_addr, mem_we and mem_wdata stay stable. Counter increments each cycle.
  - On a cycle with mem_ready=1:
    - IFETCH: i_data<=mem_rdata, i_ack<=1.
    - DACC read: d_rdata<=mem_rdata. DACC write: d_rdata unchanged.
    - DACC: d_ack<=1.
    - mem_req<=0, mem_we<=0, counter<=0, go IDLE.
- Latency: req sampled at edge N; mem_req high in cycle N+1; with mem_ready in N+1, ack is high in cycle N+2. Back-to-back grants give at most one access per 2 cycles.
- Watchdog:
  - Applies when TIMEOUT>0 and the counter reaches TIMEOUT with mem_ready=0.
  - Ack the active port; data output unchanged.
  - Drop mem_req, set timeout_err=1 (sticky until reset), go IDLE.
  - mem_ready and timeout in the same cycle: the mem_ready completion wins, no error.
- Counter width: clog2(TIMEOUT+1), saturating; never wraps.
- stall = (i_req & ~i_ack) | (d_req & ~d_ack), combinational.
- i_ack and d_ack are never high in the same cycle. Acks are exactly one cycle wide.
- Requests dropped before ack: the access in flight completes to memory; the ack pulse still occurs and may be ignored.
- Reset mid-access: mem_req drops immediately (async); no ack is generated.
- Address/data inputs change while granted: ignored, because values were latched at grant.

Test Plan:
- Single fetch: i_req=1, i_addr=16'h3000, mem_ready=1 with mem_rdata=16'h1261 in first mem_req cycle -> mem_addr=3000, mem_we=0; i_ack in cycle N+2 with i_data=16'h1261; stall low after ack.
- Collision: i_req and d_req (read, d_addr=16'h3010) asserted same cycle -> DACC granted first (mem_addr=3010); IFETCH granted in the IDLE cycle after d_ack; exactly one ack each.
- Write: d_req=1, d_rd=0, d_addr=16'h4000, d_wdata=16'hBEEF, mem_ready after 3 wait cycles -> mem_we=1, mem_wdata=BEEF stable 4 cycles; d_ack once; d_rdata unchanged.
- Watchdog: TIMEOUT=15, fetch with mem_ready stuck 0 -> after 15 mem_req cycles i_ack pulses, timeout_err=1 and stays 1; next fetch with mem_ready=1 completes normally.
- Async reset mid-DACC: assert reset between edges -> mem_req, mem_we and the acks go 0 immediately; after release state is IDLE; a held d_req is re-granted.
- Held request after ack: i_req kept high through i_ack -> no second grant in the ack cycle; regrant one cycle later, with only one memory access per ack.

Source files
------------

// File: rtl/lc3_mem_arbiter.sv
// lc3_mem_arbiter: shares one single-ported unified memory between the LC3 fetch
// stage (instruction side) and the MemAccess stage (data side).
//
// Ports:
//   clk, reset          system clock; asynchronous active-high reset
//   i_req/i_addr        fetch request (held until i_ack) and fetch address (pc)
//   i_data/i_ack        fetched instruction, valid during the one-cycle i_ack pulse
//   d_req/d_rd          data request (held until d_ack); 1 = read, 0 = write
//   d_addr/d_wdata      data address and write data
//   d_rdata/d_ack       read data, updated on read completion; one-cycle d_ack pulse
//   mem_req/mem_we      memory access strobe and write enable
//   mem_addr/mem_wdata  memory address and write data, stable for a whole access
//   mem_rdata/mem_ready memory read data; mem_ready ends the current access
//   stall               some request is pending and not yet acked
//   timeout_err         sticky watchdog flag, cleared only by reset
module lc3_mem_arbiter #(
   parameter int unsigned ADDR_W  = 16,
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned TIMEOUT = 15  // 0 disables the watchdog
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [DATA_W-1:0] i_data,
   output logic              i_ack,
   input  logic              d_req,
   input  logic              d_rd,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_ack,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output logic              stall,
   output logic              timeout_err
);

   localparam int unsigned   CntW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CntW-1:0] CntMax = (TIMEOUT > 0) ? CntW'(TIMEOUT) : '1;

   typedef enum logic [1:0] {StIdle, StIfetch, StDacc} state_e;

   state_e              state_q, state_d;
   logic [CntW-1:0]     cnt_q, cnt_d;
   logic                mem_req_q, mem_req_d;
   logic                mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
   logic [DATA_W-1:0]   i_data_q, i_data_d;
   logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
   logic                i_ack_q, i_ack_d;
   logic                d_ack_q, d_ack_d;
   logic                timeout_err_q, timeout_err_d;
   logic                wd_fire;
   logic                done;

   // The counter reads 0 in the first mem_req cycle, so firing at TIMEOUT-1 means it
   // would reach TIMEOUT on this edge: mem_req stays high for exactly TIMEOUT cycles.
   // mem_ready has priority, so a late completion is never reported as an error.
   assign wd_fire = (TIMEOUT > 0) && (cnt_q == CntW'(TIMEOUT - 1)) && !mem_ready;
   assign done    = mem_ready || wd_fire;

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      mem_req_d     = mem_req_q;
      mem_we_d      = mem_we_q;
      mem_addr_d    = mem_addr_q;
      mem_wdata_d   = mem_wdata_q;
      i_data_d      = i_data_q;
      d_rdata_d     = d_rdata_q;
      i_ack_d       = 1'b0;
      d_ack_d       = 1'b0;
      timeout_err_d = timeout_err_q;

      unique case (state_q)
         StIdle: begin
            cnt_d = '0;
            // Data first: it belongs to the older instruction. A request whose ack is
            // high right now is the one just served, so it is not granted again.
            if (d_req && !d_ack_q) begin
               mem_addr_d  = d_addr;
               mem_wdata_d = d_wdata;
               mem_we_d    = ~d_rd;
               mem_req_d   = 1'b1;
               state_d     = StDacc;
            end else if (i_req && !i_ack_q) begin
               mem_addr_d = i_addr;
               mem_we_d   = 1'b0;
               mem_req_d  = 1'b1;
               state_d    = StIfetch;
            end
         end
         StIfetch, StDacc: begin
            cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + CntW'(1);
            if (done) begin
               if (state_q == StIfetch) begin
                  i_ack_d = 1'b1;
                  if (mem_ready) i_data_d = mem_rdata;
               end else begin
                  d_ack_d = 1'b1;
                  if (mem_ready && !mem_we_q) d_rdata_d = mem_rdata;
               end
               if (!mem_ready) timeout_err_d = 1'b1;
               mem_req_d = 1'b0;
               mem_we_d  = 1'b0;
               cnt_d     = '0;
               state_d   = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= StIdle;
         cnt_q         <= '0;
         mem_req_q     <= 1'b0;
         mem_we_q      <= 1'b0;
         mem_addr_q    <= '0;
         mem_wdata_q   <= '0;
         i_data_q      <= '0;
         d_rdata_q     <= '0;
         i_ack_q       <= 1'b0;
         d_ack_q       <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         mem_req_q     <= mem_req_d;
         mem_we_q      <= mem_we_d;
         mem_addr_q    <= mem_addr_d;
         mem_wdata_q   <= mem_wdata_d;
         i_data_q      <= i_data_d;
         d_rdata_q     <= d_rdata_d;
         i_ack_q       <= i_ack_d;
         d_ack_q       <= d_ack_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign mem_req     = mem_req_q;
   assign mem_we      = mem_we_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wdata   = mem_wdata_q;
   assign i_data      = i_data_q;
   assign d_rdata     = d_rdata_q;
   assign i_ack       = i_ack_q;
   assign d_ack       = d_ack_q;
   assign timeout_err = timeout_err_q;
   assign stall       = (i_req & ~i_ack_q) | (d_req & ~d_ack_q);

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Self-checking bench for lc3_mem_arbiter: a memory responder with configurable wait
// states, an ack scoreboard, and directed fetch/data/watchdog/reset scenarios.
module tb_lc3_mem_arbiter;

   localparam int unsigned TO = 15;

   logic        clk;
   logic        reset;
   logic        i_req;
   logic [15:0] i_addr;
   logic [15:0] i_data;
   logic        i_ack;
   logic        d_req;
   logic        d_rd;
   logic [15:0] d_addr;
   logic [15:0] d_wdata;
   logic [15:0] d_rdata;
   logic        d_ack;
   logic        mem_req;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;
   logic        mem_ready;
   logic        stall;
   logic        timeout_err;

   lc3_mem_arbiter #(
      .ADDR_W (16),
      .DATA_W (16),
      .TIMEOUT(TO)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .i_req      (i_req),
      .i_addr     (i_addr),
      .i_data     (i_data),
      .i_ack      (i_ack),
      .d_req      (d_req),
      .d_rd       (d_rd),
      .d_addr     (d_addr),
      .d_wdata    (d_wdata),
      .d_rdata    (d_rdata),
      .d_ack      (d_ack),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .mem_ready  (mem_ready),
      .stall      (stall),
      .timeout_err(timeout_err)
   );

   typedef struct {
      bit          is_d;
      logic [15:0] val;
   } sb_entry_t;

   sb_entry_t   sb_q[$];
   int          n_cmp = 0;
   int          n_mis = 0;
   int          wait_cfg = 0;
   bit          mem_stuck = 0;
   logic [15:0] exp_i_data = '0;
   logic [15:0] exp_d_rdata = '0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1_000_000;
      $display("FAIL global_time_limit: got running expected finished");
      $fatal(1);
   end

   function automatic logic [15:0] mem_val(input logic [15:0] a);
      return (a == 16'h3000) ? 16'h1261 : (a ^ 16'hA5C3);
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic push(input bit is_d, input logic [15:0] v);
      sb_entry_t e;
      e.is_d = is_d;
      e.val  = v;
      sb_q.push_back(e);
   endtask

   // Memory responder: mem_ready after wait_cfg wait cycles of a held mem_req.
   initial begin : responder
      int wait_ctr;
      wait_ctr  = 0;
      mem_ready = 1'b0;
      mem_rdata = 16'hDEAD;
      forever begin
         @(negedge clk);
         if (mem_req && !mem_stuck) begin
            if (wait_ctr == wait_cfg) begin
               mem_ready = 1'b1;
               mem_rdata = mem_val(mem_addr);
               wait_ctr  = 0;
            end else begin
               mem_ready = 1'b0;
               mem_rdata = 16'hDEAD;
               wait_ctr++;
            end
         end else begin
            mem_ready = 1'b0;
            mem_rdata = 16'hDEAD;
            wait_ctr  = 0;
         end
      end
   end

   // Scoreboard: every ack pops the oldest expectation.
   initial begin : monitor
      sb_entry_t e;
      forever begin
         @(negedge clk);
         if (i_ack || d_ack) begin
            check("ack_exclusive", 32'(i_ack & d_ack), 0);
            if (sb_q.size() == 0) begin
               check("sb_unexpected_ack", 1, 0);
            end else begin
               e = sb_q.pop_front();
               check("sb_port", 32'(d_ack), 32'(e.is_d));
               check("sb_data", 32'(d_ack ? d_rdata : i_data), 32'(e.val));
            end
         end
      end
   end

   task automatic wait_ack(input bit is_d, input int budget, output int lat, output int req_cyc,
                           output int stable_cyc, output logic [15:0] f_addr,
                           output logic f_we, output logic [15:0] f_wdata);
      bit seen;
      seen = 0;
      lat = 0;
      req_cyc = 0;
      stable_cyc = 0;
      f_addr = '0;
      f_we = 1'b0;
      f_wdata = '0;
      while (!seen && lat < budget) begin
         @(negedge clk);
         lat++;
         if (mem_req) begin
            if (req_cyc == 0) begin
               f_addr  = mem_addr;
               f_we    = mem_we;
               f_wdata = mem_wdata;
            end
            if (mem_addr == f_addr && mem_we == f_we && mem_wdata == f_wdata) stable_cyc++;
            req_cyc++;
         end
         if (is_d ? d_ack : i_ack) seen = 1;
      end
      if (!seen) check("ack_within_budget", 0, 1);
   endtask

   initial begin : main
      int lat, rc, sc, nd, ni, kd, ki, na, k1, k2, nreq;
      logic [15:0] fa, fwd;
      logic        fwe;

      reset = 1'b1;
      i_req = 1'b0;
      i_addr = '0;
      d_req = 1'b0;
      d_rd = 1'b1;
      d_addr = '0;
      d_wdata = '0;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_mem_req", 32'(mem_req), 0);
      check("rst_mem_we", 32'(mem_we), 0);
      check("rst_acks", 32'({i_ack, d_ack}), 0);
      check("rst_timeout_err", 32'(timeout_err), 0);
      check("rst_mem_addr", 32'(mem_addr), 0);
      check("rst_mem_wdata", 32'(mem_wdata), 0);
      check("rst_data_outs", 32'({i_data, d_rdata}), 0);
      check("rst_stall", 32'(stall), 0);
      reset = 1'b0;

      // Single fetch, memory ready in the first mem_req cycle
      @(posedge clk); #1;
      i_addr = 16'h3000;
      i_req  = 1'b1;
      push(0, 16'h1261);
      exp_i_data = 16'h1261;
      #1 check("fetch_stall_pending", 32'(stall), 1);
      wait_ack(0, 10, lat, rc, sc, fa, fwe, fwd);
      check("fetch_latency", lat, 3);
      check("fetch_req_cycles", rc, 1);
      check("fetch_mem_addr", 32'(fa), 'h3000);
      check("fetch_mem_we", 32'(fwe), 0);
      check("fetch_stall_at_ack", 32'(stall), 0);
      i_req = 1'b0;
      #1 check("fetch_stall_after", 32'(stall), 0);

      // Collision: data read granted first, fetch in the IDLE cycle carrying d_ack
      @(posedge clk); #1;
      d_rd   = 1'b1;
      d_addr = 16'h3010;
      i_addr = 16'h3002;
      d_req  = 1'b1;
      i_req  = 1'b1;
      push(1, mem_val(16'h3010));
      push(0, mem_val(16'h3002));
      exp_d_rdata = mem_val(16'h3010);
      exp_i_data  = mem_val(16'h3002);
      nd = 0; ni = 0; kd = 0; ki = 0;
      for (int k = 1; k <= 20 && !(nd > 0 && ni > 0); k++) begin
         @(negedge clk);
         if (k == 2) begin
            check("coll_first_addr", 32'(mem_addr), 'h3010);
            check("coll_first_we", 32'(mem_we), 0);
         end
         if (kd != 0 && k == kd + 1) begin
            check("coll_i_grant_req", 32'(mem_req), 1);
            check("coll_i_grant_addr", 32'(mem_addr), 'h3002);
         end
         if (d_ack) begin nd++; kd = k; d_req = 1'b0; end
         if (i_ack) begin ni++; ki = k; i_req = 1'b0; end
      end
      repeat (4) begin
         @(negedge clk);
         if (d_ack) nd++;
         if (i_ack) ni++;
      end
      check("coll_d_acks", nd, 1);
      check("coll_i_acks", ni, 1);
      check("coll_d_ack_cycle", kd, 3);
      check("coll_i_ack_cycle", ki, 5);

      // Write with 3 wait states; d_rdata must keep the last read value
      wait_cfg = 3;
      @(posedge clk); #1;
      d_rd    = 1'b0;
      d_addr  = 16'h4000;
      d_wdata = 16'hBEEF;
      d_req   = 1'b1;
      push(1, exp_d_rdata);
      wait_ack(1, 15, lat, rc, sc, fa, fwe, fwd);
      d_req = 1'b0;
      check("wr_latency", lat, 6);
      check("wr_req_cycles", rc, 4);
      check("wr_stable_cycles", sc, 4);
      check("wr_mem_addr", 32'(fa), 'h4000);
      check("wr_mem_we", 32'(fwe), 1);
      check("wr_mem_wdata", 32'(fwd), 'hBEEF);
      wait_cfg = 0;

      // Watchdog: memory never ready
      mem_stuck = 1;
      @(posedge clk); #1;
      i_addr = 16'h3004;
      i_req  = 1'b1;
      push(0, exp_i_data);
      wait_ack(0, 40, lat, rc, sc, fa, fwe, fwd);
      i_req = 1'b0;
      check("wd_req_cycles", rc, TO);
      check("wd_latency", lat, TO + 2);
      check("wd_err_set", 32'(timeout_err), 1);
      mem_stuck = 0;
      repeat (3) @(negedge clk);
      check("wd_err_sticky", 32'(timeout_err), 1);
      check("wd_mem_req_dropped", 32'(mem_req), 0);

      @(posedge clk); #1;
      i_addr = 16'h3004;
      i_req  = 1'b1;
      push(0, mem_val(16'h3004));
      exp_i_data = mem_val(16'h3004);
      wait_ack(0, 10, lat, rc, sc, fa, fwe, fwd);
      i_req = 1'b0;
      check("wd_next_fetch_latency", lat, 3);
      check("wd_err_still_set", 32'(timeout_err), 1);

      // Held request: no regrant in the ack cycle, regrant on the next one
      @(posedge clk); #1;
      i_addr = 16'h3006;
      i_req  = 1'b1;
      push(0, mem_val(16'h3006));
      push(0, mem_val(16'h3006));
      exp_i_data = mem_val(16'h3006);
      na = 0; k1 = 0; k2 = 0; nreq = 0;
      for (int k = 1; k <= 15 && na < 2; k++) begin
         @(negedge clk);
         if (mem_req) nreq++;
         if (k1 != 0 && k == k1 + 1) check("held_no_grant_after_ack", 32'(mem_req), 0);
         if (k1 != 0 && k == k1 + 2) check("held_regrant", 32'(mem_req), 1);
         if (i_ack) begin
            na++;
            if (na == 1) k1 = k;
            else begin k2 = k; i_req = 1'b0; end
         end
      end
      check("held_first_ack", k1, 3);
      check("held_ack_spacing", k2 - k1, 3);
      check("held_accesses", nreq, 2);

      // Asynchronous reset in the middle of a data write
      wait_cfg = 5;
      @(posedge clk); #1;
      d_rd    = 1'b0;
      d_addr  = 16'h3020;
      d_wdata = 16'h1234;
      d_req   = 1'b1;
      repeat (3) @(negedge clk);
      check("rstmid_req_before", 32'(mem_req), 1);
      check("rstmid_we_before", 32'(mem_we), 1);
      #2 reset = 1'b1;
      #1;
      check("rstmid_req_async", 32'(mem_req), 0);
      check("rstmid_we_async", 32'(mem_we), 0);
      check("rstmid_acks_async", 32'({i_ack, d_ack}), 0);
      check("rstmid_err_cleared", 32'(timeout_err), 0);
      check("rstmid_data_cleared", 32'({i_data, d_rdata}), 0);
      @(negedge clk);
      reset = 1'b0;
      sb_q.delete();
      exp_d_rdata = '0;
      exp_i_data  = '0;
      wait_cfg = 1;
      push(1, exp_d_rdata);
      wait_ack(1, 10, lat, rc, sc, fa, fwe, fwd);
      d_req = 1'b0;
      check("rstmid_regrant_latency", lat, 3);
      check("rstmid_regrant_addr", 32'(fa), 'h3020);
      check("rstmid_regrant_we", 32'(fwe), 1);
      check("rstmid_regrant_wdata", 32'(fwd), 'h1234);

      repeat (3) @(negedge clk);
      check("sb_empty", sb_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
